// File: rtl/calc_pkg.sv
// Shared encodings for the calculator entry path: FSM states, operator codes
// and bit positions on the conditioned input bus.
package calc_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_RES = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } op_e;

    localparam int IDX_ADD = 0;
    localparam int IDX_SUB = 1;
    localparam int IDX_MUL = 2;
    localparam int IDX_EQ  = 3;
    localparam int IDX_DLO = 4;
    localparam int IDX_DHI = 7;
    localparam int IDX_ENT = 8;

endpackage

// File: rtl/calc_alu.sv
// Combinational arithmetic on two unsigned W-bit operands; 2W-bit magnitude
// plus a sign flag for subtraction.
module calc_alu
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]   opa_i,
    input  logic [W-1:0]   opb_i,
    input  op_e            op_i,
    output logic [2*W-1:0] mag_o,
    output logic           neg_o
);

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;

    assign a_ext = {{W{1'b0}}, opa_i};
    assign b_ext = {{W{1'b0}}, opb_i};

    always_comb begin
        mag_o = '0;
        neg_o = 1'b0;
        case (op_i)
            OP_ADD: mag_o = a_ext + b_ext;
            OP_SUB: begin
                // Report magnitude and carry the sign separately for the display.
                neg_o = (opa_i < opb_i);
                mag_o = neg_o ? (b_ext - a_ext) : (a_ext - b_ext);
            end
            OP_MUL: mag_o = a_ext * b_ext;
            default: mag_o = '0;
        endcase
    end

endmodule

// File: rtl/calc_entry_fsm.sv
// Operand/operator entry controller: builds two hex operands from ENTER pulses,
// latches an operator and holds the computed result for the display stage.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [8:0]     in,
    output logic [2*W-1:0] disp,
    output logic           neg,
    output logic           res_valid,
    output logic [1:0]     state,
    output logic [1:0]     op
);

    state_e         state_q;
    op_e            op_q;
    logic [W-1:0]   opa_q;
    logic [W-1:0]   opb_q;
    logic [2*W-1:0] res_q;
    logic           neg_q;

    logic [3:0]     digit;
    logic           cmd_eq;
    logic           cmd_ent;
    logic           cmd_opr;
    op_e            cmd_op;
    logic [W+3:0]   opa_sh;
    logic [W+3:0]   opb_sh;
    logic [2*W-1:0] alu_mag;
    logic           alu_neg;

    // EQUALS > ENTER > MUL > SUB > ADD; lower-priority pulses are dropped.
    assign digit   = in[IDX_DHI:IDX_DLO];
    assign cmd_eq  = in[IDX_EQ];
    assign cmd_ent = in[IDX_ENT] & ~cmd_eq;
    assign cmd_opr = ~cmd_eq & ~in[IDX_ENT] & (in[IDX_MUL] | in[IDX_SUB] | in[IDX_ADD]);

    always_comb begin
        cmd_op = OP_ADD;
        if (in[IDX_MUL])      cmd_op = OP_MUL;
        else if (in[IDX_SUB]) cmd_op = OP_SUB;
    end

    assign opa_sh = {opa_q, digit};
    assign opb_sh = {opb_q, digit};

    calc_alu #(.W(W)) u_alu (
        .opa_i (opa_q),
        .opb_i (opb_q),
        .op_i  (op_q),
        .mag_o (alu_mag),
        .neg_o (alu_neg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_A;
            op_q    <= OP_ADD;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_A: begin
                    if (cmd_eq) begin
                        opa_q <= '0;
                    end else if (cmd_ent) begin
                        opa_q <= opa_sh[W-1:0];
                    end else if (cmd_opr) begin
                        op_q    <= cmd_op;
                        opb_q   <= '0;
                        state_q <= S_B;
                    end
                end
                S_B: begin
                    if (cmd_eq) begin
                        res_q   <= alu_mag;
                        neg_q   <= alu_neg;
                        state_q <= S_RES;
                    end else if (cmd_ent) begin
                        opb_q <= opb_sh[W-1:0];
                    end else if (cmd_opr) begin
                        op_q <= cmd_op;
                    end
                end
                S_RES: begin
                    if (cmd_eq) begin
                        op_q    <= OP_ADD;
                        opa_q   <= '0;
                        opb_q   <= '0;
                        res_q   <= '0;
                        neg_q   <= 1'b0;
                        state_q <= S_A;
                    end else if (cmd_ent) begin
                        opa_q   <= {{(W-4){1'b0}}, digit};
                        opb_q   <= '0;
                        res_q   <= '0;
                        neg_q   <= 1'b0;
                        state_q <= S_A;
                    end
                end
                default: begin
                    state_q <= S_A;
                    op_q    <= OP_ADD;
                    opa_q   <= '0;
                    opb_q   <= '0;
                    res_q   <= '0;
                    neg_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        disp = '0;
        case (state_q)
            S_A:     disp = {{W{1'b0}}, opa_q};
            S_B:     disp = {{W{1'b0}}, opb_q};
            S_RES:   disp = res_q;
            default: disp = '0;
        endcase
    end

    assign res_valid = (state_q == S_RES);
    assign neg       = res_valid & neg_q;
    assign state     = state_q;
    assign op        = op_q;

endmodule

// File: doc/calc_entry_fsm.md
# calc_entry_fsm

Operand/operator entry controller for the digital calculator. It consumes the 9-bit conditioned input bus from the debounce/rising-edge stage: one-cycle pulses on bits 3:0 and 8, raw switch levels on bits 7:4. It assembles two hex operands digit by digit, latches an operator, and computes and holds the result. Its outputs drive the display stage.

## Interface

Parameters:
- `W`, default 8: operand width in bits. Must be a multiple of 4 and at least 4.

Ports:
- `clk`, input, 1: system clock, rising-edge.
- `rst`, input, 1: asynchronous, active-low reset (0 = reset).
- `in`, input, 9: conditioned bus.
  - [0] ADD pulse, [1] SUB pulse, [2] MUL pulse, [3] EQUALS pulse.
  - [7:4] digit value (switch level).
  - [8] ENTER pulse.
- `disp`, output, 2W: value to display (magnitude).
- `neg`, output, 1: displayed result is negative.
- `res_valid`, output, 1: high while a computed result is displayed.
- `state`, output, 2: current FSM state.
- `op`, output, 2: latched operator.

## Operation

- States:
  - `S_A` (0): entering operand A.
  - `S_B` (1): entering operand B.
  - `S_RES` (2): result held.
  - Code 3 is illegal; it recovers to `S_A` with all registers cleared.
- Command decode per cycle uses the pulse bits only. Priority is EQUALS > ENTER > MUL > SUB > ADD; lower-priority pulses in the same cycle are dropped.
- Digit entry: on ENTER, opX <= {opX[W-5:0], in[7:4]}. The top nibble shifts out and is lost (wrap, no error). `in[7:4]` is sampled in the ENTER cycle only.
- `S_A`:
  - ENTER shifts into opA.
  - Operator pulse latches `op` (ADD=0, SUB=1, MUL=2), clears opB, goes to `S_B`.
  - EQUALS clears opA, stays in `S_A`.
- `S_B`:
  - ENTER shifts into opB.
  - Operator pulse replaces `op`, stays in `S_B`; opB is untouched.
  - EQUALS registers the result and goes to `S_RES`.
- `S_RES`:
  - ENTER loads opA <= zero-extended `in[7:4]`, clears opB and result, goes to `S_A`.
  - EQUALS clears all and goes to `S_A`.
  - Operator pulses are ignored.
- Arithmetic (unsigned operands, 2W-bit result):
  - ADD: opA+opB, zero-extended.
  - SUB: |opA−opB|, with neg=1 iff opA<opB.
  - MUL: opA*opB, full 2W bits.
  - No overflow is possible.
- `disp`:
  - `S_A`: zero-extended opA.
  - `S_B`: zero-extended opB.
  - `S_RES`: the registered result.
  - `neg` is 0 outside `S_RES`.

## Timing

- All state, operand, op and result registers update on the rising edge of `clk`.
- `disp`, `neg`, `res_valid`, `state` and `op` are registered or derived only from registers; no combinational path from `in`.
- Latency:
  - A pulse sampled at edge N is reflected in the outputs after edge N.
  - EQUALS at edge N gives `res_valid`=1 and the result on `disp` after edge N, held until the next ENTER or EQUALS.
- Back-to-back pulses on consecutive cycles are each honoured.
- A pulse longer than one cycle is processed once per cycle; upstream guarantees single-cycle pulses.
- Reset: `rst`=0 asynchronously forces the following, regardless of the state the FSM is in:
  - state = `S_A`
  - opA = opB = result = 0
  - op = ADD
  - disp = 0, neg = 0, res_valid = 0
- Reset release: synchronous de-assertion is handled upstream. The first command is accepted on the first edge with `rst`=1.

## Structure

- Package `calc_pkg`:
  - state encodings `S_A`/`S_B`/`S_RES`
  - op codes ADD/SUB/MUL
  - bus bit-index constants (`IDX_ADD`=0, `IDX_SUB`=1, `IDX_MUL`=2, `IDX_EQ`=3, `IDX_ENT`=8, digit field 7:4)
- Sub-module `calc_alu`, combinational, parameter W:
  - inputs: opA, opB, op
  - outputs: 2W-bit magnitude and neg
- The FSM registers the `calc_alu` outputs on EQUALS.

## Test plan

Scenarios use W=8.

- Reset: hold `rst`=0 in the middle of any state → `state`=0, `disp`=0x0000, `neg`=0, `res_valid`=0 immediately, without waiting for a clock edge.
- Add: digits 3, 7 (ENTER each) → `disp`=0x0037. ADD, digit 5 → `state`=1, `disp`=0x0005. EQUALS → next cycle `disp`=0x003C, `res_valid`=1, `neg`=0.
- Negative subtract: A=0x05, SUB, B=0x12, EQUALS → `disp`=0x000D, `neg`=1.
- Full-width multiply: A=0xFF, MUL, B=0xFF, EQUALS → `disp`=0xFE01.
- Digit wrap: digits 1, 2, 3 in `S_A` → `disp`=0x0023. Operator change in `S_B`: ADD then MUL before EQUALS with A=0x23, B=0x02 → `disp`=0x0046.
- Simultaneous pulses: EQUALS and ENTER in the same cycle in `S_B` → EQUALS wins, `S_RES` entered, opB unchanged.
- Leaving `S_RES`: ENTER with `in[7:4]`=9 → `state`=0, `disp`=0x0009.
